// File: rtl/cg_operand_queue.sv
// Constant generator (CG1/R2, CG2/R3) for NCH operand channels, with size masking,
// feeding a DEPTH-entry valid/ready queue between decode and operand fetch.
module cg_operand_queue #(
   parameter int WIDTH = 20,
   parameter int NCH   = 2,
   parameter int DEPTH = 2
) (
   input  logic                 MCLK,
   input  logic                 reset_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 Format,
   input  logic                 BW,
   input  logic                 AL,
   input  logic [4*NCH-1:0]     regA,
   input  logic [2*NCH-1:0]     mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH*NCH-1:0] out_value,
   output logic [NCH-1:0]       out_gen
);

   // Handshake: a set transfers in on a cycle where in_valid & in_ready (and no flush);
   // the head leaves on a cycle where out_valid & out_ready. in_ready does not depend on
   // out_ready, so a full queue never accepts, even if the head is popped that cycle.
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH*NCH-1:0] w_val;
   logic [NCH-1:0]       w_gen;
   logic [WIDTH-1:0]     w_mask;
   logic                 w_push;
   logic                 w_pop;

   logic [WIDTH*NCH-1:0] r_val_mem [DEPTH];
   logic [NCH-1:0]       r_gen_mem [DEPTH];
   logic [PW-1:0]        r_wptr;
   logic [PW-1:0]        r_rptr;
   logic [CW-1:0]        r_count;

   // Byte keeps [7:0]; word keeps [15:0]; address keeps all bits (only reachable when WIDTH>16).
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_mask[i] = (i < 8) || (!BW && ((i < 16) || !AL));
      end
   end

   always_comb begin
      logic [3:0]       v_reg;
      logic [1:0]       v_md;
      logic [WIDTH-1:0] v_c;
      logic             v_g;
      w_val = '0;
      w_gen = '0;
      for (int c = 0; c < NCH; c++) begin
         v_reg = regA[4*c +: 4];
         v_md  = mode[2*c +: 2];
         v_c   = '0;
         v_g   = 1'b0;
         if (c == 0) begin
            if (v_reg == 4'd2) begin
               v_g = (v_md != 2'b00);
               case (v_md)
                  2'b10:   v_c = WIDTH'(4);
                  2'b11:   v_c = WIDTH'(8);
                  default: v_c = '0;
               endcase
            end else if (v_reg == 4'd3) begin
               v_g = 1'b1;
               case (v_md)
                  2'b01:   v_c = WIDTH'(1);
                  2'b10:   v_c = WIDTH'(2);
                  2'b11:   v_c = '1;
                  default: v_c = '0;
               endcase
            end
         end else if (!Format) begin
            v_g = ((v_reg == 4'd2) && v_md[0]) || (v_reg == 4'd3);
         end
         w_gen[c]               = v_g;
         w_val[WIDTH*c +: WIDTH] = v_g ? (v_c & w_mask) : '0;
      end
   end

   assign in_ready  = (r_count < CW'(DEPTH));
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid & in_ready & !flush;
   assign w_pop     = out_valid & out_ready & !flush;
   assign out_value = out_valid ? r_val_mem[r_rptr] : '0;
   assign out_gen   = out_valid ? r_gen_mem[r_rptr] : '0;

   // Storage needs no reset: it is only observed through the out_valid gate.
   always_ff @(posedge MCLK) begin
      if (w_push) begin
         r_val_mem[r_wptr] <= w_val;
         r_gen_mem[r_wptr] <= w_gen;
      end
   end

   always_ff @(posedge MCLK or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cg_operand_queue.sv
// Directed bench for cg_operand_queue (WIDTH=20, NCH=2, DEPTH=2): a vector table for the
// generator plus hand-written sequences for reset, backpressure, streaming and flush.
module tb_cg_operand_queue;

   localparam int WIDTH = 20;
   localparam int NCH   = 2;
   localparam int DEPTH = 2;
   localparam int NV    = 14;

   logic                 MCLK;
   logic                 reset_n;
   logic                 flush;
   logic                 in_valid;
   logic                 in_ready;
   logic                 Format;
   logic                 BW;
   logic                 AL;
   logic [4*NCH-1:0]     regA;
   logic [2*NCH-1:0]     mode;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH*NCH-1:0] out_value;
   logic [NCH-1:0]       out_gen;

   typedef struct {
      logic        fmt;
      logic        bw;
      logic        al;
      logic [7:0]  rega;
      logic [3:0]  md;
      logic [39:0] ev;
      logic [1:0]  eg;
   } vec_t;

   vec_t        vt [NV];
   logic [41:0] exp_q [$];
   logic [41:0] exp_e;
   int          n_checks;
   int          n_fail;

   cg_operand_queue #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH)) dut (
      .MCLK      (MCLK),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Format    (Format),
      .BW        (BW),
      .AL        (AL),
      .regA      (regA),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_value (out_value),
      .out_gen   (out_gen)
   );

   // Clock and reset
   initial MCLK = 1'b0;
   always #5 MCLK = ~MCLK;

   function automatic vec_t mk(input logic f, input logic b, input logic a, input logic [7:0] r,
                               input logic [3:0] m, input logic [39:0] v, input logic [1:0] g);
      vec_t t;
      t.fmt = f; t.bw = b; t.al = a; t.rega = r; t.md = m; t.ev = v; t.eg = g;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Driver: present vector i on the input side (in_valid set separately).
   task automatic drive(input int i);
      Format = vt[i].fmt;
      BW     = vt[i].bw;
      AL     = vt[i].al;
      regA   = vt[i].rega;
      mode   = vt[i].md;
   endtask

   task automatic step();
      @(posedge MCLK);
      #1;
   endtask

   // Scoreboard: compare head against the oldest expected entry without consuming it.
   task automatic chk_head(input string name);
      if (exp_q.size() == 0) begin
         chk({name, "_empty"}, {63'd0, out_valid}, 64'd0);
      end else begin
         exp_e = exp_q[0];
         chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
         chk({name, "_value"}, {24'd0, out_value}, {24'd0, exp_e[39:0]});
         chk({name, "_gen"}, {62'd0, out_gen}, {62'd0, exp_e[41:40]});
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset_n   = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      Format    = 1'b0;
      BW        = 1'b0;
      AL        = 1'b1;
      regA      = '0;
      mode      = '0;

      vt[0]  = mk(0, 0, 1, 8'h23, 4'b0111, 40'h00000_0FFFF, 2'b11);
      vt[1]  = mk(0, 0, 0, 8'h23, 4'b0111, 40'h00000_FFFFF, 2'b11);
      vt[2]  = mk(0, 1, 0, 8'h23, 4'b0111, 40'h00000_000FF, 2'b11);
      vt[3]  = mk(0, 0, 1, 8'h22, 4'b0111, 40'h00000_00008, 2'b11);
      vt[4]  = mk(1, 0, 1, 8'h34, 4'b0110, 40'h00000_00000, 2'b00);
      vt[5]  = mk(0, 0, 1, 8'h22, 4'b0000, 40'h00000_00000, 2'b00);
      vt[6]  = mk(0, 0, 1, 8'h32, 4'b0001, 40'h00000_00000, 2'b11);
      vt[7]  = mk(0, 0, 0, 8'h42, 4'b0110, 40'h00000_00004, 2'b01);
      vt[8]  = mk(0, 0, 1, 8'h03, 4'b0000, 40'h00000_00000, 2'b01);
      vt[9]  = mk(0, 0, 1, 8'h13, 4'b0001, 40'h00000_00001, 2'b01);
      vt[10] = mk(1, 0, 1, 8'h33, 4'b0110, 40'h00000_00002, 2'b01);
      vt[11] = mk(0, 1, 1, 8'h13, 4'b1111, 40'h00000_000FF, 2'b01);
      vt[12] = mk(0, 0, 1, 8'h23, 4'b1011, 40'h00000_0FFFF, 2'b01);
      vt[13] = mk(0, 0, 0, 8'h35, 4'b0011, 40'h00000_00000, 2'b10);

      // Reset state
      #12;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_value", {24'd0, out_value}, 64'd0);
      chk("rst_out_gen", {62'd0, out_gen}, 64'd0);
      @(negedge MCLK);
      reset_n = 1'b1;
      step();

      // Generator table: push into an empty queue, check head one edge later, pop.
      out_ready = 1'b1;
      for (int i = 0; i < NV; i++) begin
         drive(i);
         in_valid = 1'b1;
         exp_q.push_back({vt[i].eg, vt[i].ev});
         step();
         in_valid = 1'b0;
         chk_head($sformatf("vec%0d", i));
         step();
         void'(exp_q.pop_front());
         chk($sformatf("vec%0d_drained", i), {63'd0, out_valid}, 64'd0);
      end

      // Backpressure: fill with A,B; C waits while head A is held stable.
      out_ready = 1'b0;
      drive(0); in_valid = 1'b1; exp_q.push_back({vt[0].eg, vt[0].ev});
      step();
      drive(3); exp_q.push_back({vt[3].eg, vt[3].ev});
      step();
      drive(7);
      chk("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_full_count", {62'd0, dut.r_count}, 64'd2);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("bp_stall_in_ready", {63'd0, in_ready}, 64'd0);
         chk_head("bp_stall_head");
      end
      exp_q.push_back({vt[7].eg, vt[7].ev});
      out_ready = 1'b1;
      step();
      void'(exp_q.pop_front());
      chk_head("bp_head_b");
      chk("bp_count_after_a", {62'd0, dut.r_count}, 64'd1);
      step();
      void'(exp_q.pop_front());
      in_valid = 1'b0;
      chk_head("bp_head_c");
      step();
      void'(exp_q.pop_front());
      chk_head("bp_drained");

      // Streaming: push and pop every cycle across pointer wrap.
      for (int i = 0; i < 10; i++) begin
         drive((i * 5) % NV);
         in_valid = 1'b1;
         exp_q.push_back({vt[(i * 5) % NV].eg, vt[(i * 5) % NV].ev});
         step();
         if (i > 0) void'(exp_q.pop_front());
         chk_head($sformatf("stream%0d", i));
         chk($sformatf("stream%0d_count", i), {62'd0, dut.r_count}, 64'd1);
      end
      in_valid = 1'b0;
      step();
      void'(exp_q.pop_front());
      chk_head("stream_drained");

      // Flush with one entry queued and a concurrent push offered.
      out_ready = 1'b0;
      drive(1); in_valid = 1'b1;
      step();
      chk("fl_pre_valid", {63'd0, out_valid}, 64'd1);
      drive(2); flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
      chk("fl_count", {62'd0, dut.r_count}, 64'd0);
      chk("fl_out_value", {24'd0, out_value}, 64'd0);
      chk("fl_out_gen", {62'd0, out_gen}, 64'd0);
      step();
      chk("fl_dropped", {63'd0, out_valid}, 64'd0);
      drive(9); in_valid = 1'b1; exp_q.push_back({vt[9].eg, vt[9].ev});
      step();
      in_valid = 1'b0;
      chk_head("fl_first_push");
      out_ready = 1'b1;
      step();
      void'(exp_q.pop_front());
      out_ready = 1'b0;

      // Asynchronous reset mid-stream with two entries queued.
      drive(0); in_valid = 1'b1;
      step();
      drive(3);
      step();
      in_valid = 1'b0;
      chk("ar_pre_count", {62'd0, dut.r_count}, 64'd2);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
      chk("ar_out_value", {24'd0, out_value}, 64'd0);
      chk("ar_out_gen", {62'd0, out_gen}, 64'd0);
      chk("ar_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge MCLK);
      reset_n = 1'b1;
      drive(10); in_valid = 1'b1; exp_q.push_back({vt[10].eg, vt[10].ev});
      step();
      in_valid = 1'b0;
      chk_head("ar_first_push");
      chk("ar_first_count", {62'd0, dut.r_count}, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
